// File: rtl/lynx_tape_pkg.sv
//==============================================================================
// Module   : lynx_tape_pkg
// Brief    : State encoding and default 24 MHz timing for the Lynx tape player.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package lynx_tape_pkg;

    typedef logic [2:0] state_t;

    localparam state_t st_idle   = 3'd0;
    localparam state_t st_leader = 3'd1;
    localparam state_t st_fetch  = 3'd2;
    localparam state_t st_bits   = 3'd3;
    localparam state_t st_tail   = 3'd4;

    localparam int HALF0_24M       = 5000;
    localparam int HALF1_24M       = 10000;
    localparam int LEADER_BITS_DEF = 768;

endpackage

`default_nettype wire

// File: rtl/lynx_tape_bitgen.sv
//==============================================================================
// Module   : lynx_tape_bitgen
// Brief    : One square cycle per bit: high for H clocks, then low for H clocks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lynx_tape_bitgen #(
    parameter int HALF0 = 5000,
    parameter int HALF1 = 10000,
    parameter int CW    = 18
) (
    input  logic clock24,
    input  logic reset,
    input  logic clear,
    input  logic start,
    input  logic bitVal,
    output logic level,
    output logic bitDone
);

    localparam logic [CW-1:0] c_LOAD0 = CW'(HALF0 - 1);
    localparam logic [CW-1:0] c_LOAD1 = CW'(HALF1 - 1);

    logic          r_active;
    logic          r_low;
    logic          r_bit;
    logic [CW-1:0] r_cnt;

    // A start arriving in the final clock restarts immediately, so bits abut.
    always_ff @(posedge clock24) begin
        if (reset || clear) begin
            r_active <= 1'b0;
            r_low    <= 1'b0;
            r_bit    <= 1'b0;
            r_cnt    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_low    <= 1'b0;
            r_bit    <= bitVal;
            r_cnt    <= bitVal ? c_LOAD1 : c_LOAD0;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                if (r_low) begin
                    r_active <= 1'b0;
                    r_low    <= 1'b0;
                end else begin
                    r_low <= 1'b1;
                    r_cnt <= r_bit ? c_LOAD1 : c_LOAD0;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign level   = r_active && !r_low;
    assign bitDone = r_active && r_low && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lynx_tape_player.sv
//==============================================================================
// Module   : lynx_tape_player
// Brief    : Serialises buffered cassette bytes into Lynx pulse-width audio.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lynx_tape_player
    import lynx_tape_pkg::*;
#(
    parameter int HALF0       = HALF0_24M,
    parameter int HALF1       = HALF1_24M,
    parameter int LEADER_BITS = LEADER_BITS_DEF,
    parameter int TAIL_CLKS   = 240000,
    parameter int CW          = 18
) (
    input  logic       clock24,
    input  logic       reset,
    input  logic       play,
    input  logic       stop,
    input  logic [7:0] byteData,
    input  logic       byteValid,
    input  logic       byteLast,
    output logic       byteReady,
    output logic       tapeOut,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int c_LW = $clog2(LEADER_BITS + 1);

    state_t          r_state;
    logic [7:0]      r_byte;
    logic            r_last;
    logic [2:0]      r_bitIdx;
    logic [c_LW-1:0] r_leadCnt;
    logic [CW-1:0]   r_tailCnt;
    logic            r_done;
    logic            r_underrun;

    logic w_level;
    logic w_bitDone;
    logic w_start;
    logic w_startBit;
    logic w_clear;

    assign w_clear = stop && (r_state != st_idle);

    // Next bit is launched in the final clock of the current one.
    always_comb begin
        w_start    = 1'b0;
        w_startBit = 1'b0;
        if (!stop) begin
            case (r_state)
                st_idle:   w_start = play;
                st_leader: w_start = w_bitDone && (r_leadCnt != c_LW'(1));
                st_fetch: begin
                    w_start    = byteValid;
                    w_startBit = byteData[7];
                end
                st_bits: begin
                    w_start    = w_bitDone && (r_bitIdx != 3'd0);
                    w_startBit = r_byte[r_bitIdx - 3'd1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock24) begin
        if (reset) begin
            r_state    <= st_idle;
            r_byte     <= '0;
            r_last     <= 1'b0;
            r_bitIdx   <= '0;
            r_leadCnt  <= '0;
            r_tailCnt  <= '0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_clear) begin
                r_state <= st_idle;
            end else begin
                case (r_state)
                    st_idle: begin
                        if (play && !stop) begin
                            r_state    <= st_leader;
                            r_leadCnt  <= c_LW'(LEADER_BITS);
                            r_underrun <= 1'b0;
                        end
                    end
                    st_leader: begin
                        if (w_bitDone) begin
                            r_leadCnt <= r_leadCnt - 1'b1;
                            if (r_leadCnt == c_LW'(1)) r_state <= st_fetch;
                        end
                    end
                    st_fetch: begin
                        if (byteValid) begin
                            r_byte   <= byteData;
                            r_last   <= byteLast;
                            r_bitIdx <= 3'd7;
                            r_state  <= st_bits;
                        end else begin
                            r_underrun <= 1'b1;
                        end
                    end
                    st_bits: begin
                        if (w_bitDone) begin
                            if (r_bitIdx == 3'd0) begin
                                r_state   <= r_last ? st_tail : st_fetch;
                                r_tailCnt <= CW'(TAIL_CLKS - 1);
                            end else begin
                                r_bitIdx <= r_bitIdx - 3'd1;
                            end
                        end
                    end
                    st_tail: begin
                        if (r_tailCnt == '0) begin
                            r_state <= st_idle;
                            r_done  <= 1'b1;
                        end else begin
                            r_tailCnt <= r_tailCnt - 1'b1;
                        end
                    end
                    default: r_state <= st_idle;
                endcase
            end
        end
    end

    lynx_tape_bitgen #(
        .HALF0 (HALF0),
        .HALF1 (HALF1),
        .CW    (CW)
    ) u_bitgen (
        .clock24 (clock24),
        .reset   (reset),
        .clear   (w_clear),
        .start   (w_start),
        .bitVal  (w_startBit),
        .level   (w_level),
        .bitDone (w_bitDone)
    );

    assign tapeOut   = w_level;
    assign busy      = (r_state != st_idle);
    assign byteReady = (r_state == st_fetch);
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule

`default_nettype wire
